rdc_result_collector: RTL and testbench
=======================================

Name: rdc_result_collector

Overview:
- Stage directly downstream of the redundant compute wrapper.
- Accepts each one-cycle result pulse (data plus mismatch flag) and tags it with a sequence number.
- Buffers results in a small FIFO toward the writeback consumer, with a valid/ready handshake.
- Tracks mismatch statistics, captures the first mismatching result, and raises a sticky fault when consecutive mismatches reach a threshold.

Parameters:
- WIDTH, 64: result data width.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- SEQ_W, 8: sequence tag width; wraps modulo 2^SEQ_W.
- CNT_W, 16: total-mismatch counter width; saturating.
- FAULT_THRESH, 3: consecutive mismatches that set fault; range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- res_valid  in  1  result pulse from the redundant compute wrapper (may be a single-cycle pulse).
- res_ready  out  1  FIFO can accept; drives the wrapper's out_ready.
- res_data  in  WIDTH  result data.
- res_mismatch  in  1  A/B mismatch flag for this result.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  head data.
- out_mismatch  out  1  head mismatch flag.
- out_seq  out  SEQ_W  head sequence tag.
- fault  out  1  sticky consecutive-mismatch fault.
- fault_clr  in  1  clears fault and the consecutive count.
- cnt_clr  in  1  clears mis_total, ovf and the error capture.
- mis_total  out  CNT_W  saturating total mismatch count.
- err_valid  out  1  first-mismatch capture valid.
- err_seq  out  SEQ_W  seq tag of the first captured mismatch.
- err_data  out  WIDTH  data of the first captured mismatch.
- ovf  out  1  sticky: result arrived while full and was dropped.

Behaviour:
- Reset (async, rst=1): FIFO empty, wr/rd pointers 0, seq counter 0, consecutive count 0.
  - All outputs 0 except res_ready=1.
  - Reset mid-operation discards all buffered entries and statistics.
- Accept: push when res_valid & res_ready.
  - Entry = {res_data, res_mismatch, seq}; seq increments after every push, wrapping 2^SEQ_W-1 -> 0.
  - Dropped results do not consume a seq value.
- res_ready = !full, taken from registered count only. No same-cycle pass-through when full: a push at full is refused even if a pop occurs that cycle.
- Drop: res_valid & !res_ready sets ovf (sticky until cnt_clr). The result is not counted in statistics.
- Output: out_valid = !empty; out_* reflect the head entry.
  - Pop when out_valid & out_ready.
  - out_* must hold stable while out_valid & !out_ready.
- Latency: push in cycle t -> out_valid=1 in cycle t+1 if the FIFO was empty. No combinational path from res_* to out_*.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Full/empty are decided by a count register of width $clog2(DEPTH)+1.
- Statistics update on accepted pushes only.
  - Mismatch: mis_total increments, saturating at all-ones; consec increments, saturating at 255.
  - Mismatch when err_valid=0: err_valid, err_seq and err_data capture the entry; later mismatches do not overwrite.
  - Clean result: consec resets to 0.
  - fault is set in the cycle after consec reaches FAULT_THRESH. It stays set, and further mismatches keep counting.
- fault_clr: fault<=0 and consec<=0, with clear applied first.
  - A mismatch push in the same cycle then counts as consec=1 and sets fault only if FAULT_THRESH=1.
- cnt_clr: mis_total<=0, ovf<=0, err_valid<=0, with clear applied first.
  - A same-cycle mismatch push then counts as mis_total=1 and is captured.
- fault_clr and cnt_clr are independent and may be asserted together.
- Statistics never stall the data path. A mismatching result is forwarded exactly like a clean one, with out_mismatch=1.

Decomposition:
- Package rdc_pkg:
  - Default constants RDC_WIDTH=64, RDC_SEQ_W=8.
  - Parameterised struct typedef rdc_entry_t {data, mismatch, seq}, shared with the wrapper's testbench.
- Sub-module rdc_sync_fifo: generic DEPTH×entry register FIFO with push/pop/full/empty/count. Its reset is asynchronous active-high.
- The statistics/fault logic stays in rdc_result_collector.

Test Plan:
- Single result 0xDEAD_BEEF, mismatch=0, out_ready=1 -> out_valid in the next cycle with out_seq=0, out_mismatch=0; mis_total stays 0.
- 5 pushes with out_ready=0, DEPTH=4 -> res_ready=0 after the 4th push, 5th dropped, ovf=1.
  - Draining then yields seq 0,1,2,3 in order.
  - The next accepted push gets seq 4.
- Mismatch pattern 1,1,0,1,1,1 -> fault=0 through the 5th result and 1 after the 6th.
  - mis_total=5; err_seq=0 with the first result's data.
- fault_clr in the same cycle as a mismatch push, FAULT_THRESH=3 -> fault=0 and internal consec=1. Two more mismatches -> fault=1.
- 260 clean pushes with continuous drain -> out_seq wraps 255->0 with no gap, out_valid never drops for an accepted item, and no ovf.
- rst asserted while FIFO holds 3 entries and fault=1 -> all outputs 0 and res_ready=1 immediately (asynchronously). The first push after release gets seq 0.

Source files
------------

// File: rtl/rdc_pkg.sv
// Shared constants and entry layout for the redundant-compute result collector
// and the benches that drive the wrapper.
package rdc_pkg;

  localparam int RDC_WIDTH        = 64;
  localparam int RDC_SEQ_W        = 8;
  localparam int RDC_DEPTH        = 4;
  localparam int RDC_CNT_W        = 16;
  localparam int RDC_FAULT_THRESH = 3;
  localparam int RDC_CONSEC_W     = 8;

  // Default-width entry; the collector re-declares it locally from its own parameters.
  typedef struct packed {
    logic [RDC_WIDTH-1:0] data;
    logic                 mismatch;
    logic [RDC_SEQ_W-1:0] seq;
  } rdc_entry_t;

  function automatic logic [RDC_CONSEC_W-1:0] consec_inc(input logic [RDC_CONSEC_W-1:0] v);
    return (&v) ? v : v + RDC_CONSEC_W'(1);
  endfunction

endpackage

// File: rtl/rdc_sync_fifo.sv
// Generic register FIFO: DEPTH entries of ENTRY_W bits, head readable combinationally,
// full/empty derived from a registered occupancy count.
module rdc_sync_fifo #(
  parameter int ENTRY_W = 8,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_entry,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       head_entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_reg [DEPTH];
  logic [AW-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [AW:0]        count_reg, count_next;
  logic [DEPTH-1:0]   wr_en;
  logic               push_ok, pop_ok;

  assign full    = (count_reg == FULL_C);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign head_entry = mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push_ok && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is cleared on reset so an empty FIFO presents an all-zero head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_reg[i] <= push_entry;
      end
    end
  end

endmodule

// File: rtl/rdc_result_collector.sv
// Tags results from the redundant compute wrapper with a sequence number, buffers them
// toward writeback, and keeps mismatch statistics plus a sticky consecutive-mismatch fault.
module rdc_result_collector
  import rdc_pkg::*;
#(
  parameter int WIDTH        = RDC_WIDTH,
  parameter int DEPTH        = RDC_DEPTH,
  parameter int SEQ_W        = RDC_SEQ_W,
  parameter int CNT_W        = RDC_CNT_W,
  parameter int FAULT_THRESH = RDC_FAULT_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [WIDTH-1:0] res_data,
  input  logic             res_mismatch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mismatch,
  output logic [SEQ_W-1:0] out_seq,
  output logic             fault,
  input  logic             fault_clr,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] mis_total,
  output logic             err_valid,
  output logic [SEQ_W-1:0] err_seq,
  output logic [WIDTH-1:0] err_data,
  output logic             ovf
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             mismatch;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
  localparam logic [$clog2(DEPTH):0]   FULL_COUNT = ($clog2(DEPTH)+1)'(DEPTH);
  localparam logic [RDC_CONSEC_W-1:0]  THRESH_C   = RDC_CONSEC_W'(FAULT_THRESH);

  entry_t                 push_entry, head_entry;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   push_ok, drop, pop;

  logic [SEQ_W-1:0]        seq_reg, seq_next;
  logic [RDC_CONSEC_W-1:0] consec_reg, consec_next;
  logic                    fault_reg, fault_next;
  logic [CNT_W-1:0]        mis_total_reg, mis_total_next;
  logic                    err_valid_reg, err_valid_next;
  logic [SEQ_W-1:0]        err_seq_reg, err_seq_next;
  logic [WIDTH-1:0]        err_data_reg, err_data_next;
  logic                    ovf_reg, ovf_next;

  // Acceptance looks only at registered occupancy; a pop at full does not free a slot this cycle.
  assign res_ready = (fifo_count != FULL_COUNT);
  assign push_ok   = res_valid & res_ready;
  assign drop      = res_valid & fifo_full;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  assign push_entry = '{data: res_data, mismatch: res_mismatch, seq: seq_reg};

  rdc_sync_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_ok),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign out_data     = head_entry.data;
  assign out_mismatch = head_entry.mismatch;
  assign out_seq      = head_entry.seq;

  // Clears take effect first, so a same-cycle push is counted against the cleared state.
  always_comb begin
    seq_next       = seq_reg;
    consec_next    = fault_clr ? '0 : consec_reg;
    fault_next     = fault_clr ? 1'b0 : fault_reg;
    mis_total_next = cnt_clr ? '0 : mis_total_reg;
    err_valid_next = cnt_clr ? 1'b0 : err_valid_reg;
    err_seq_next   = err_seq_reg;
    err_data_next  = err_data_reg;
    ovf_next       = (cnt_clr ? 1'b0 : ovf_reg) | drop;

    if (push_ok) begin
      seq_next = seq_reg + SEQ_W'(1);
      if (res_mismatch) begin
        consec_next    = consec_inc(consec_next);
        mis_total_next = (&mis_total_next) ? mis_total_next : mis_total_next + CNT_W'(1);
        if (consec_next >= THRESH_C) fault_next = 1'b1;
        if (!err_valid_next) begin
          err_valid_next = 1'b1;
          err_seq_next   = seq_reg;
          err_data_next  = res_data;
        end
      end else begin
        consec_next = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_reg       <= '0;
      consec_reg    <= '0;
      fault_reg     <= 1'b0;
      mis_total_reg <= '0;
      err_valid_reg <= 1'b0;
      err_seq_reg   <= '0;
      err_data_reg  <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      seq_reg       <= seq_next;
      consec_reg    <= consec_next;
      fault_reg     <= fault_next;
      mis_total_reg <= mis_total_next;
      err_valid_reg <= err_valid_next;
      err_seq_reg   <= err_seq_next;
      err_data_reg  <= err_data_next;
      ovf_reg       <= ovf_next;
    end
  end

  assign fault     = fault_reg;
  assign mis_total = mis_total_reg;
  assign err_valid = err_valid_reg;
  assign err_seq   = err_seq_reg;
  assign err_data  = err_data_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_rdc_result_collector.sv
// Directed bench for rdc_result_collector: stimulus queues expected entries, a negedge
// monitor pops and compares them whenever the DUT hands one to the consumer.
module tb_rdc_result_collector;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int SEQ_W = 8;
  localparam int CNT_W = 16;
  localparam int TH    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             res_valid = 1'b0;
  logic             res_ready;
  logic [WIDTH-1:0] res_data = '0;
  logic             res_mismatch = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_mismatch;
  logic [SEQ_W-1:0] out_seq;
  logic             fault;
  logic             fault_clr = 1'b0;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] mis_total;
  logic             err_valid;
  logic [SEQ_W-1:0] err_seq;
  logic [WIDTH-1:0] err_data;
  logic             ovf;

  rdc_result_collector #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SEQ_W(SEQ_W), .CNT_W(CNT_W), .FAULT_THRESH(TH)
  ) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_mismatch(res_mismatch),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mismatch(out_mismatch), .out_seq(out_seq),
    .fault(fault), .fault_clr(fault_clr), .cnt_clr(cnt_clr),
    .mis_total(mis_total), .err_valid(err_valid), .err_seq(err_seq), .err_data(err_data),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             mis;
    logic [SEQ_W-1:0] seq;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               checks = 0;
  int               errors = 0;
  logic [SEQ_W-1:0] exp_seq = '0;

  logic             hold = 1'b0;
  logic [WIDTH-1:0] hold_data;
  logic             hold_mis;
  logic [SEQ_W-1:0] hold_seq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare each handed-over entry and verify the head holds while stalled.
  always @(negedge clk) begin
    if (hold && out_valid) begin
      chk("hold_data", out_data, hold_data);
      chk("hold_seq", {56'd0, out_seq}, {56'd0, hold_seq});
      chk("hold_mis", {63'd0, out_mismatch}, {63'd0, hold_mis});
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual_seq=%0d required=none", out_seq);
      end else begin
        mon_e = exp_q.pop_front();
        $display("pop seq=%0d data=%0h mis=%0b", out_seq, out_data, out_mismatch);
        chk("out_data", out_data, mon_e.data);
        chk("out_mis", {63'd0, out_mismatch}, {63'd0, mon_e.mis});
        chk("out_seq", {56'd0, out_seq}, {56'd0, mon_e.seq});
      end
    end
    hold      = out_valid && !out_ready && !rst;
    hold_data = out_data;
    hold_mis  = out_mismatch;
    hold_seq  = out_seq;
  end

  // Called at posedge+1; returns at the next posedge+1.
  task automatic push(input logic [63:0] d, input logic m, input logic acc);
    res_valid    = 1'b1;
    res_data     = d;
    res_mismatch = m;
    chk("res_ready", {63'd0, res_ready}, {63'd0, acc});
    if (acc) begin
      exp_q.push_back('{d, m, exp_seq});
      exp_seq = exp_seq + 8'd1;
    end
    $display("push data=%0h mis=%0b accept=%0b", d, m, acc);
    @(posedge clk);
    #1;
    res_valid    = 1'b0;
    res_mismatch = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_res_ready"}, {63'd0, res_ready}, 64'd1);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_out_mis"}, {63'd0, out_mismatch}, 64'd0);
    chk({tag, "_out_seq"}, {56'd0, out_seq}, 64'd0);
    chk({tag, "_fault"}, {63'd0, fault}, 64'd0);
    chk({tag, "_mis_total"}, {48'd0, mis_total}, 64'd0);
    chk({tag, "_err_valid"}, {63'd0, err_valid}, 64'd0);
    chk({tag, "_err_seq"}, {56'd0, err_seq}, 64'd0);
    chk({tag, "_err_data"}, err_data, 64'd0);
    chk({tag, "_ovf"}, {63'd0, ovf}, 64'd0);
  endtask

  // Raise rst mid-cycle and check outputs before any clock edge arrives.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_idle(tag);
    exp_q.delete();
    exp_seq = '0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain actual_left=%0d required=0", tag, exp_q.size());
    end
  endtask

  initial begin
    logic [5:0] pat;
    pat = 6'b111011;  // bit i = mismatch of result i: 1,1,0,1,1,1

    #1 rst = 1'b1;
    #2 check_idle("por");
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single clean result, one-cycle latency
    out_ready = 1'b1;
    push(64'hDEAD_BEEF, 1'b0, 1'b1);
    chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
    wait_drain("t1");
    chk("t1_mis_total", {48'd0, mis_total}, 64'd0);

    // Fill to full with stalled consumer, overflow, drain, continue seq
    do_reset("t2_rst");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(64'h1000 + 64'(i), 1'b0, 1'b1);
    push(64'h1004, 1'b0, 1'b0);
    chk("t2_ovf", {63'd0, ovf}, 64'd1);
    out_ready = 1'b1;
    wait_drain("t2a");
    push(64'h2000, 1'b0, 1'b1);
    wait_drain("t2b");
    chk("t2_ovf_sticky", {63'd0, ovf}, 64'd1);
    chk("t2_mis_total", {48'd0, mis_total}, 64'd0);

    // Consecutive-mismatch fault
    do_reset("t3_rst");
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(64'h100 + 64'(i), pat[i], 1'b1);
      chk("t3_fault", {63'd0, fault}, {63'd0, (i == 5)});
    end
    chk("t3_mis_total", {48'd0, mis_total}, 64'd5);
    chk("t3_err_valid", {63'd0, err_valid}, 64'd1);
    chk("t3_err_seq", {56'd0, err_seq}, 64'd0);
    chk("t3_err_data", err_data, 64'h100);

    // fault_clr with same-cycle mismatch restarts the run at 1
    fault_clr = 1'b1;
    push(64'h300, 1'b1, 1'b1);
    fault_clr = 1'b0;
    chk("t4_fault_a", {63'd0, fault}, 64'd0);
    push(64'h301, 1'b1, 1'b1);
    chk("t4_fault_b", {63'd0, fault}, 64'd0);
    push(64'h302, 1'b1, 1'b1);
    chk("t4_fault_c", {63'd0, fault}, 64'd1);
    chk("t4_mis_total", {48'd0, mis_total}, 64'd8);

    // cnt_clr with same-cycle mismatch: counted and captured afresh
    cnt_clr = 1'b1;
    push(64'h400, 1'b1, 1'b1);
    cnt_clr = 1'b0;
    chk("t4_cnt_mis_total", {48'd0, mis_total}, 64'd1);
    chk("t4_cnt_err_valid", {63'd0, err_valid}, 64'd1);
    chk("t4_cnt_err_seq", {56'd0, err_seq}, 64'd9);
    chk("t4_cnt_err_data", err_data, 64'h400);
    chk("t4_cnt_fault", {63'd0, fault}, 64'd1);
    wait_drain("t4");

    // 260 streaming results: seq wraps with no gap, no overflow
    do_reset("t5_rst");
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      push(64'(i), 1'b0, 1'b1);
      chk("t5_out_valid", {63'd0, out_valid}, 64'd1);
    end
    wait_drain("t5");
    chk("t5_ovf", {63'd0, ovf}, 64'd0);
    chk("t5_mis_total", {48'd0, mis_total}, 64'd0);

    // Asynchronous reset with 3 buffered entries and fault set
    do_reset("t6_pre");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(64'h500 + 64'(i), 1'b1, 1'b1);
    chk("t6_fault", {63'd0, fault}, 64'd1);
    chk("t6_out_valid", {63'd0, out_valid}, 64'd1);
    do_reset("t6_rst");
    out_ready = 1'b1;
    push(64'h600, 1'b0, 1'b1);
    wait_drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
